// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer
//
// Purpose:
//   Sequences machine-mode trap entry and mret exit for an in-order pipeline.
//   A synchronous exception or an enabled, pending interrupt is accepted in
//   IDLE. The sequencer then stalls the front end until the pipeline drains,
//   emits a one-cycle commit strobe carrying the latched trap fields, and
//   emits a one-cycle PC redirect to the handler. An mret request produces a
//   one-cycle commit strobe plus a redirect to mepc and unmasks interrupts.
//
// Configuration macro:
//   TRAP_VECTORED_EN  - when defined, interrupts taken with mtvec[1:0]=2'b01
//                       jump to {mtvec[XLEN-1:2],2'b00} + 4*code. Exceptions
//                       always use the direct base. When undefined, every
//                       trap uses the direct base and mtvec[1:0] is ignored.
//
// Parameters:
//   XLEN       - data / PC width
//   CODE_BITS  - exception cause width (must hold the value 11)
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   sync_exc_req/_code/_pc/_addr   synchronous exception request and info
//   current_pc                     resume PC recorded for interrupts
//   mret_req                       mret retire pulse
//   pipe_drained                   pipeline is empty
//   mie, mtie, meie, mtip, meip    CSR global enable / enables / pendings
//   mtvec, mepc                    trap vector base and return PC
//   pipe_hold                      stall fetch/issue while sequencing
//   activate_exception             one-cycle trap commit strobe
//   is_interrupt, exception_code,
//   exception_PC, exception_addr   trap fields, valid with the commit strobe
//   csr_mret_active                one-cycle mret commit strobe
//   redirect_valid, redirect_pc    one-cycle PC redirect
//   in_trap                        handler active, interrupts masked
// ---------------------------------------------------------------------------
module trap_sequencer #(
    parameter int XLEN      = 32,
    parameter int CODE_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sync_exc_req,
    input  logic [CODE_BITS-1:0] sync_exc_code,
    input  logic [XLEN-1:0]      sync_exc_pc,
    input  logic [XLEN-1:0]      sync_exc_addr,
    input  logic [XLEN-1:0]      current_pc,
    input  logic                 mret_req,
    input  logic                 pipe_drained,
    input  logic                 mie,
    input  logic                 mtie,
    input  logic                 meie,
    input  logic                 mtip,
    input  logic                 meip,
    input  logic [XLEN-1:0]      mtvec,
    input  logic [XLEN-1:0]      mepc,
    output logic                 pipe_hold,
    output logic                 activate_exception,
    output logic                 is_interrupt,
    output logic [CODE_BITS-1:0] exception_code,
    output logic [XLEN-1:0]      exception_PC,
    output logic [XLEN-1:0]      exception_addr,
    output logic                 csr_mret_active,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 in_trap
);

    localparam logic [CODE_BITS-1:0] CODE_EXT_INT   = CODE_BITS'(11);
    localparam logic [CODE_BITS-1:0] CODE_TIMER_INT = CODE_BITS'(7);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        COMMIT,
        REDIRECT,
        MRET
    } state_t;

    state_t state;
    state_t state_next;

    // Trap fields captured at acceptance and replayed during COMMIT.
    logic                 is_int_reg;
    logic [CODE_BITS-1:0] code_reg;
    logic [XLEN-1:0]      pc_reg;
    logic [XLEN-1:0]      addr_reg;
    logic                 in_trap_reg;

    // ------------------------------------------------------------------
    // Request arbitration (only acted upon in IDLE)
    // ------------------------------------------------------------------
    logic                 int_eligible;
    logic                 take_ext;
    logic                 take_timer;
    logic                 sel_trap;
    logic                 sel_is_int;
    logic [CODE_BITS-1:0] sel_code;
    logic [XLEN-1:0]      sel_pc;
    logic [XLEN-1:0]      sel_addr;

    // Interrupts are masked globally and while a handler is running;
    // synchronous exceptions are never masked.
    assign int_eligible = mie && !in_trap_reg;
    assign take_ext     = int_eligible && meip && meie;
    assign take_timer   = int_eligible && mtip && mtie;
    assign sel_trap     = sync_exc_req || take_ext || take_timer;

    always_comb begin
        sel_is_int = 1'b0;
        sel_code   = sync_exc_code;
        sel_pc     = sync_exc_pc;
        sel_addr   = sync_exc_addr;
        if (!sync_exc_req) begin
            if (take_ext) begin
                sel_is_int = 1'b1;
                sel_code   = CODE_EXT_INT;
                sel_pc     = current_pc;
                sel_addr   = '0;
            end else if (take_timer) begin
                sel_is_int = 1'b1;
                sel_code   = CODE_TIMER_INT;
                sel_pc     = current_pc;
                sel_addr   = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handler target
    // ------------------------------------------------------------------
    logic [XLEN-1:0] target_base;
    logic [XLEN-1:0] trap_target;

    assign target_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    logic [XLEN-1:0] vector_offset;

    // 4*code; the add is XLEN bits wide so a high base wraps naturally.
    assign vector_offset = XLEN'(code_reg) << 2;
    assign trap_target   = (is_int_reg && (mtvec[1:0] == 2'b01))
                         ? (target_base + vector_offset)
                         : target_base;
`else
    logic unused_mtvec_mode;

    assign unused_mtvec_mode = ^mtvec[1:0];
    assign trap_target       = target_base;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. Outputs are decoded from state alone, so
    // every strobe lasts exactly one cycle and reset zeroes them at once.
    // ------------------------------------------------------------------
    always_comb begin
        state_next         = state;
        pipe_hold          = 1'b0;
        activate_exception = 1'b0;
        is_interrupt       = 1'b0;
        exception_code     = '0;
        exception_PC       = '0;
        exception_addr     = '0;
        csr_mret_active    = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;

        case (state)
            IDLE: begin
                // A trap outranks mret, so a simultaneous mret is dropped.
                if (sel_trap) begin
                    state_next = DRAIN;
                end else if (mret_req) begin
                    state_next = MRET;
                end
            end
            DRAIN: begin
                pipe_hold = 1'b1;
                if (pipe_drained) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                pipe_hold          = 1'b1;
                activate_exception = 1'b1;
                is_interrupt       = is_int_reg;
                exception_code     = code_reg;
                exception_PC       = pc_reg;
                exception_addr     = addr_reg;
                state_next         = REDIRECT;
            end
            REDIRECT: begin
                pipe_hold      = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = trap_target;
                state_next     = IDLE;
            end
            MRET: begin
                pipe_hold       = 1'b1;
                csr_mret_active = 1'b1;
                redirect_valid  = 1'b1;
                redirect_pc     = mepc;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Trap field capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_int_reg <= 1'b0;
            code_reg   <= '0;
            pc_reg     <= '0;
            addr_reg   <= '0;
        end else if ((state == IDLE) && sel_trap) begin
            is_int_reg <= sel_is_int;
            code_reg   <= sel_code;
            pc_reg     <= sel_pc;
            addr_reg   <= sel_addr;
        end
    end

    // ------------------------------------------------------------------
    // Handler-active flag: raised as the commit retires, dropped as mret
    // retires. It is visible from the REDIRECT cycle onward.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_trap_reg <= 1'b0;
        end else if (state == COMMIT) begin
            in_trap_reg <= 1'b1;
        end else if (state == MRET) begin
            in_trap_reg <= 1'b0;
        end
    end

    assign in_trap = in_trap_reg;

endmodule

// File: tb/tb_trap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trap_sequencer
//
// Directed bench for trap_sequencer. A transaction-level model predicts the
// output vector for every cycle from the trap/mret rules; a compare process
// checks the DUT against it on every falling edge. Directed sequences add
// literal expectations at known cycles so the model itself is pinned.
// ---------------------------------------------------------------------------
module tb_trap_sequencer;

    localparam int XLEN = 32;
    localparam int CB   = 4;

`ifdef TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            sync_exc_req;
    logic [CB-1:0]   sync_exc_code;
    logic [XLEN-1:0] sync_exc_pc;
    logic [XLEN-1:0] sync_exc_addr;
    logic [XLEN-1:0] current_pc;
    logic            mret_req;
    logic            pipe_drained;
    logic            mie, mtie, meie, mtip, meip;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic            pipe_hold;
    logic            activate_exception;
    logic            is_interrupt;
    logic [CB-1:0]   exception_code;
    logic [XLEN-1:0] exception_PC;
    logic [XLEN-1:0] exception_addr;
    logic            csr_mret_active;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            in_trap;

    trap_sequencer #(.XLEN(XLEN), .CODE_BITS(CB)) dut (
        .clk                (clk),
        .reset              (reset),
        .sync_exc_req       (sync_exc_req),
        .sync_exc_code      (sync_exc_code),
        .sync_exc_pc        (sync_exc_pc),
        .sync_exc_addr      (sync_exc_addr),
        .current_pc         (current_pc),
        .mret_req           (mret_req),
        .pipe_drained       (pipe_drained),
        .mie                (mie),
        .mtie               (mtie),
        .meie               (meie),
        .mtip               (mtip),
        .meip               (meip),
        .mtvec              (mtvec),
        .mepc               (mepc),
        .pipe_hold          (pipe_hold),
        .activate_exception (activate_exception),
        .is_interrupt       (is_interrupt),
        .exception_code     (exception_code),
        .exception_PC       (exception_PC),
        .exception_addr     (exception_addr),
        .csr_mret_active    (csr_mret_active),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .in_trap            (in_trap)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one expected output vector per cycle.
    // ------------------------------------------------------------------
    typedef struct {
        logic            hold;
        logic            act;
        logic            isint;
        logic [CB-1:0]   code;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] addr;
        logic            mret;
        logic            rv;
        logic [XLEN-1:0] rpc;
    } snap_t;

    function automatic snap_t zero_snap();
        snap_t s;
        s = '{hold: 1'b0, act: 1'b0, isint: 1'b0, code: '0, pc: '0,
              addr: '0, mret: 1'b0, rv: 1'b0, rpc: '0};
        return s;
    endfunction

    function automatic logic [XLEN-1:0] handler_pc(input logic [XLEN-1:0] tv,
                                                   input logic intr,
                                                   input logic [CB-1:0] c);
        logic [XLEN-1:0] base;
        base = tv & ~32'h3;
        if (VEC && intr && (tv[1:0] == 2'b01)) begin
            return base + 32'(c) * 32'd4;
        end
        return base;
    endfunction

    snap_t           cur;
    snap_t           s;
    snap_t           q[$];
    bit              draining;
    logic            in_trap_m;
    logic            ie;
    logic            t_int;
    logic [CB-1:0]   t_code;
    logic [XLEN-1:0] t_pc;
    logic [XLEN-1:0] t_addr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            draining  = 1'b0;
            q.delete();
            in_trap_m = 1'b0;
            cur       = zero_snap();
        end else begin
            if (!cur.hold) begin
                // The cycle that just ended was idle: arbitrate requests.
                ie = mie && !in_trap_m;
                if (sync_exc_req) begin
                    t_int = 1'b0; t_code = sync_exc_code;
                    t_pc = sync_exc_pc; t_addr = sync_exc_addr;
                    draining = 1'b1;
                end else if (ie && meip && meie) begin
                    t_int = 1'b1; t_code = 4'd11; t_pc = current_pc; t_addr = '0;
                    draining = 1'b1;
                end else if (ie && mtip && mtie) begin
                    t_int = 1'b1; t_code = 4'd7; t_pc = current_pc; t_addr = '0;
                    draining = 1'b1;
                end else if (mret_req) begin
                    s = zero_snap();
                    s.hold = 1'b1; s.mret = 1'b1; s.rv = 1'b1; s.rpc = mepc;
                    q.push_back(s);
                end
            end else if (draining && pipe_drained) begin
                draining = 1'b0;
                s = zero_snap();
                s.hold = 1'b1; s.act = 1'b1; s.isint = t_int; s.code = t_code;
                s.pc = t_pc; s.addr = t_addr;
                q.push_back(s);
                s = zero_snap();
                s.hold = 1'b1; s.rv = 1'b1; s.rpc = handler_pc(mtvec, t_int, t_code);
                q.push_back(s);
            end
            if (cur.act)  in_trap_m = 1'b1;
            if (cur.mret) in_trap_m = 1'b0;
            if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = zero_snap();
                cur.hold = draining;
            end
        end
    end

    // Compare process: DUT vs model on every falling edge.
    always @(negedge clk) begin
        check("cmp_pipe_hold",       pipe_hold,          cur.hold);
        check("cmp_activate",        activate_exception, cur.act);
        check("cmp_is_interrupt",    is_interrupt,       cur.isint);
        check("cmp_exception_code",  exception_code,     cur.code);
        check("cmp_exception_pc",    exception_PC,       cur.pc);
        check("cmp_exception_addr",  exception_addr,     cur.addr);
        check("cmp_mret_active",     csr_mret_active,    cur.mret);
        check("cmp_redirect_valid",  redirect_valid,     cur.rv);
        check("cmp_redirect_pc",     redirect_pc,        cur.rpc);
        check("cmp_in_trap",         in_trap,            in_trap_m);
    end

    int act_count  = 0;
    int mret_count = 0;
    always @(negedge clk) begin
        if (activate_exception === 1'b1) act_count++;
        if (csr_mret_active === 1'b1)    mret_count++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_commit(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (activate_exception === 1'b1) seen = 1'b1;
        end
        if (!seen) check({name, "_commit_timeout"}, 0, 1);
    endtask

    task automatic wait_redirect(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (redirect_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) check({name, "_redirect_timeout"}, 0, 1);
    endtask

    task automatic pulse_mret(input logic [XLEN-1:0] ret_pc);
        step();
        mepc     = ret_pc;
        mret_req = 1'b1;
        step();
        mret_req = 1'b0;
    endtask

    int snap_cnt;

    initial begin
        sync_exc_req = 0; sync_exc_code = '0; sync_exc_pc = '0; sync_exc_addr = '0;
        current_pc = '0; mret_req = 0; pipe_drained = 1;
        mie = 0; mtie = 0; meie = 0; mtip = 0; meip = 0;
        mtvec = 32'h8000; mepc = '0;

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_pipe_hold", pipe_hold, 0);
        check("reset_in_trap", in_trap, 0);
        check("reset_redirect_valid", redirect_valid, 0);
        step();
        reset = 1'b0;
        step();

        // Sync exception, minimum latency.
        sync_exc_req = 1; sync_exc_code = 4'd2; sync_exc_pc = 32'h100; sync_exc_addr = 32'h55;
        step();
        sync_exc_req = 0;
        @(negedge clk);
        check("lat_drain_hold", pipe_hold, 1);
        check("lat_drain_noact", activate_exception, 0);
        @(negedge clk);
        check("exc_act", activate_exception, 1);
        check("exc_code", exception_code, 2);
        check("exc_pc", exception_PC, 32'h100);
        check("exc_addr", exception_addr, 32'h55);
        check("exc_isint", is_interrupt, 0);
        @(negedge clk);
        check("exc_redirect_valid", redirect_valid, 1);
        check("exc_redirect_pc", redirect_pc, 32'h8000);
        @(negedge clk);
        check("exc_in_trap_set", in_trap, 1);
        check("exc_hold_released", pipe_hold, 0);
        $display("txn exc code=2 done t=%0t", $time);

        // Lone mret.
        pulse_mret(32'h204);
        @(negedge clk);
        check("mret_active", csr_mret_active, 1);
        check("mret_redirect_pc", redirect_pc, 32'h204);
        @(negedge clk);
        check("mret_in_trap_clr", in_trap, 0);
        $display("txn mret done t=%0t", $time);

        // Both interrupts pending: external wins.
        step();
        mtvec = 32'h8001; current_pc = 32'h1234;
        mie = 1; meie = 1; mtie = 1; meip = 1; mtip = 1;
        wait_commit("ext");
        check("ext_code", exception_code, 11);
        check("ext_isint", is_interrupt, 1);
        check("ext_pc", exception_PC, 32'h1234);
        check("ext_addr", exception_addr, 0);
        wait_redirect("ext");
        check("ext_redirect_pc", redirect_pc, VEC ? 32'h802C : 32'h8000);
        snap_cnt = act_count;
        repeat (6) step();
        check("masked_no_timer", act_count - snap_cnt, 0);
        check("masked_in_trap", in_trap, 1);
        $display("txn ext irq done t=%0t", $time);

        // Handler clears meip and returns; timer then taken.
        meip = 0;
        pulse_mret(32'h300);
        wait_commit("tmr");
        check("tmr_code", exception_code, 7);
        check("tmr_isint", is_interrupt, 1);
        wait_redirect("tmr");
        check("tmr_redirect_pc", redirect_pc, VEC ? 32'h801C : 32'h8000);
        mtip = 0;
        pulse_mret(32'h400);
        repeat (3) step();
        check("tmr_ret_in_trap", in_trap, 0);
        $display("txn timer irq done t=%0t", $time);

        // Exception and mret together: mret discarded; mode 3 stays direct.
        mtvec = 32'h8003;
        snap_cnt = mret_count;
        sync_exc_req = 1; mret_req = 1; sync_exc_code = 4'd5;
        sync_exc_pc = 32'h400; sync_exc_addr = 32'h40C;
        step();
        sync_exc_req = 0; mret_req = 0;
        wait_commit("both");
        check("both_code", exception_code, 5);
        wait_redirect("both");
        check("both_redirect_pc", redirect_pc, 32'h8000);
        step();
        check("both_no_mret", mret_count - snap_cnt, 0);

        // Sync exception while already in a handler.
        sync_exc_req = 1; sync_exc_code = 4'd3; sync_exc_pc = 32'h500; sync_exc_addr = 32'h0;
        step();
        sync_exc_req = 0;
        wait_commit("nested");
        check("nested_code", exception_code, 3);
        check("nested_pc", exception_PC, 32'h500);
        wait_redirect("nested");
        pulse_mret(32'h204);
        @(negedge clk);
        check("late_mret_rpc", redirect_pc, 32'h204);
        check("late_mret_active", csr_mret_active, 1);
        @(negedge clk);
        check("late_mret_in_trap", in_trap, 0);
        $display("txn exc+mret done t=%0t", $time);

        // Reset while stuck in DRAIN.
        step();
        pipe_drained = 0;
        sync_exc_req = 1; sync_exc_code = 4'd1; sync_exc_pc = 32'h600;
        step();
        sync_exc_req = 0;
        repeat (5) step();
        check("drain_hold", pipe_hold, 1);
        snap_cnt = act_count;
        reset = 1'b1;
        @(negedge clk);
        check("abort_hold", pipe_hold, 0);
        check("abort_act", activate_exception, 0);
        check("abort_rv", redirect_valid, 0);
        check("abort_rpc", redirect_pc, 0);
        step();
        step();
        reset = 1'b0;
        pipe_drained = 1;
        repeat (5) step();
        check("abort_no_commit", act_count - snap_cnt, 0);
        check("abort_idle", pipe_hold, 0);
        $display("txn reset-in-drain done t=%0t", $time);

        // Vectored target wrap.
        mtvec = 32'hFFFF_FFF1; current_pc = 32'h700; meip = 1;
        wait_commit("wrap");
        check("wrap_code", exception_code, 11);
        wait_redirect("wrap");
        check("wrap_redirect_pc", redirect_pc, VEC ? 32'h0000_001C : 32'hFFFF_FFF0);
        meip = 0;
        pulse_mret(32'h800);
        repeat (3) step();
        check("wrap_ret_in_trap", in_trap, 0);
        $display("txn wrap done t=%0t", $time);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and PC width.
REQ-002 SHALL have parameter CODE_BITS, default 4, exception code width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  async active-high reset
- sync_exc_req  in  1  synchronous exception pulse from pipeline
- sync_exc_code  in  CODE_BITS  exception cause
- sync_exc_pc / sync_exc_addr  in  XLEN  faulting PC / bad address
- current_pc  in  XLEN  PC to resume after an interrupt
- mret_req  in  1  mret retire pulse
- pipe_drained  in  1  pipeline empty
- mie, mtie, meie, mtip, meip  in  1  CSR enable/pending bits
- mtvec, mepc  in  XLEN  CSR values
- pipe_hold  out  1  stall fetch/issue
- activate_exception, is_interrupt  out  1  trap-commit strobe and type
- exception_code  out  CODE_BITS; exception_PC, exception_addr  out  XLEN
- csr_mret_active  out  1  mret commit strobe
- redirect_valid  out  1; redirect_pc  out  XLEN  PC redirect
- in_trap  out  1  handler active, interrupts masked

Function
REQ-005 SHALL implement states IDLE, DRAIN, COMMIT, REDIRECT, MRET.
REQ-006 In IDLE, priority: sync_exc_req > (meip&meie) > (mtip&mtie) > mret_req; interrupts eligible only when mie=1 and in_trap=0.
REQ-007 On a selected trap in IDLE, SHALL latch code (11 ext, 7 timer, else sync_exc_code), is_interrupt, PC (sync_exc_pc, or current_pc for interrupts) and addr (sync_exc_addr, 0 for interrupts), and go to DRAIN.
REQ-008 pipe_hold SHALL be 1 in DRAIN, COMMIT, REDIRECT and MRET, 0 in IDLE.
REQ-009 DRAIN SHALL persist until pipe_drained=1 is sampled, then go to COMMIT.
REQ-010 COMMIT SHALL last one cycle with activate_exception=1 and latched fields on the outputs, and set in_trap=1; then REDIRECT.
REQ-011 REDIRECT SHALL last one cycle with redirect_valid=1, then return to IDLE.
REQ-012 Direct target SHALL be {mtvec[XLEN-1:2],2'b00}.
REQ-013 mret_req in IDLE with no trap selected SHALL go to MRET: one cycle csr_mret_active=1, redirect_valid=1, redirect_pc=mepc, in_trap cleared; then IDLE.
REQ-014 sync_exc_req and mret_req in the same cycle: exception taken, mret discarded.
REQ-015 Requests arriving outside IDLE SHALL be ignored; level interrupts are re-evaluated on return to IDLE.
REQ-016 Sync exceptions SHALL be taken even when in_trap=1.
REQ-017 Strobes SHALL be single-cycle; minimum trap latency request->redirect_valid is 3 cycles (pipe_drained already 1).
REQ-018 Target arithmetic SHALL be XLEN-bit modulo 2^XLEN (wrap, no carry out).

Reset
REQ-019 Reset SHALL force IDLE, in_trap=0 and all outputs 0, including mid-sequence; an aborted trap SHALL produce no strobe.

Configuration
REQ-020 Macro TRAP_VECTORED_EN defined: interrupts with mtvec[1:0]=2'b01 SHALL target {mtvec[XLEN-1:2],2'b00}+4*code; exceptions use direct target.
REQ-021 TRAP_VECTORED_EN undefined: mtvec[1:0] ignored, all traps direct.

Verification
REQ-022 sync_exc_req code=2, pc=0x100, mtvec=0x8000, pipe_drained=1 -> activate_exception at cycle+2 with code 2, PC 0x100, is_interrupt=0; redirect_pc=0x8000 at cycle+3.
REQ-023 meip=mtip=1, meie=mtie=mie=1 together -> code 11, is_interrupt=1; mtip still pending is not taken until mret clears in_trap.
REQ-024 TRAP_VECTORED_EN defined, mtvec=0x8001, timer interrupt -> redirect_pc=0x801C; undefined -> 0x8000.
REQ-025 sync_exc_req and mret_req same cycle -> trap sequence only, csr_mret_active never 1; later lone mret with mepc=0x204 -> redirect_pc=0x204, in_trap=0.
REQ-026 pipe_drained held 0 for 5 cycles, reset asserted in DRAIN -> all outputs 0, no activate_exception, state IDLE.
REQ-027 mtvec=0xFFFFFFF1, vectored, code 11 -> redirect_pc=0x0000001C (wrap).
